// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - fetch stage state encoding and default widths
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_t;

    localparam int          FETCH_ADDR_W   = 16;
    localparam int          FETCH_INSTR_W  = 16;
    localparam logic [15:0] FETCH_RESET_PC = 16'h0000;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory read handshake (req/valid)
interface fetch_unit_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
) ();

    logic               memReq;
    logic [ADDR_W-1:0]  memAddr;
    logic               memValid;
    logic [INSTR_W-1:0] memData;

    modport master (output memReq, output memAddr, input memValid, input memData);
    modport slave  (input memReq, input memAddr, output memValid, output memData);

endinterface

// File: rtl/program_counter.sv
// rtl/program_counter.sv - program counter with increment (wrapping) or target load
module program_counter #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pcEn,
    input  logic              pcIncOrSet,
    input  logic [ADDR_W-1:0] pcTarget,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (pcEn) begin
            // Increment relies on natural modulo-2^ADDR_W wrap.
            pc <= pcIncOrSet ? pcTarget : pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch stage: PC, memory read FSM, fetch buffer, IR
// Optional issued-instruction counter built when FETCH_ICOUNT_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                INSTR_W  = FETCH_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC,
    parameter int                CNT_W    = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               fetchReq,
    input  logic               pcEn,
    input  logic               pcIncOrSet,
    input  logic [ADDR_W-1:0]  pcTarget,
    input  logic               irEn,
    fetch_unit_if.master       mem,
    output logic               fetchReady,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instruction,
    output logic [CNT_W-1:0]   instrCount
);

    fetch_state_t       state;
    logic [ADDR_W-1:0]  reqAddr;
    logic [INSTR_W-1:0] fetchBuf;
    logic               memReqR;

    program_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock      (clock),
        .reset      (reset),
        .pcEn       (pcEn),
        .pcIncOrSet (pcIncOrSet),
        .pcTarget   (pcTarget),
        .pc         (pc)
    );

    assign mem.memReq  = memReqR;
    assign mem.memAddr = reqAddr;

    // reqAddr captures the pre-update pc, so PC strobes never disturb an outstanding read.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= FETCH_IDLE;
            reqAddr     <= '0;
            fetchBuf    <= '0;
            memReqR     <= 1'b0;
            fetchReady  <= 1'b0;
            instruction <= '0;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (fetchReq) begin
                        state   <= FETCH_REQ;
                        reqAddr <= pc;
                        memReqR <= 1'b1;
                    end
                end
                FETCH_REQ: begin
                    if (mem.memValid) begin
                        state      <= FETCH_HOLD;
                        fetchBuf   <= mem.memData;
                        memReqR    <= 1'b0;
                        fetchReady <= 1'b1;
                    end
                end
                FETCH_HOLD: begin
                    if (irEn) begin
                        instruction <= fetchBuf;
                        fetchReady  <= 1'b0;
                        if (fetchReq) begin
                            state   <= FETCH_REQ;
                            reqAddr <= pc;
                            memReqR <= 1'b1;
                        end else begin
                            state <= FETCH_IDLE;
                        end
                    end
                end
                default: begin
                    state      <= FETCH_IDLE;
                    memReqR    <= 1'b0;
                    fetchReady <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_ICOUNT_EN
    logic issue;
    assign issue = (state == FETCH_HOLD) && irEn;

    always_ff @(posedge clock) begin
        if (reset) begin
            instrCount <= '0;
        end else if (issue && (instrCount != {CNT_W{1'b1}})) begin
            instrCount <= instrCount + CNT_W'(1);
        end
    end
`else
    assign instrCount = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit (vector table, hand sequence, random vs model)
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetchReq;
    logic        pcEn;
    logic        pcIncOrSet;
    logic [15:0] pcTarget;
    logic        irEn;
    logic        fetchReady;
    logic [15:0] pc;
    logic [15:0] instruction;
    logic [31:0] instrCount;

    int vectors = 0;
    int fails   = 0;

    fetch_unit_if #(.ADDR_W(16), .INSTR_W(16)) mem ();

    fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .fetchReq    (fetchReq),
        .pcEn        (pcEn),
        .pcIncOrSet  (pcIncOrSet),
        .pcTarget    (pcTarget),
        .irEn        (irEn),
        .mem         (mem),
        .fetchReady  (fetchReady),
        .pc          (pc),
        .instruction (instruction),
        .instrCount  (instrCount)
    );

    always #5 clock = ~clock;

    // Reference: an outstanding read and a buffered word are tracked as plain flags.
    logic        m_busy;
    logic        m_have;
    logic [15:0] m_addr;
    logic [15:0] m_buf;
    logic [15:0] m_pc;
    logic [15:0] m_ins;
    logic [31:0] m_cnt;

    task automatic model_step();
        logic [15:0] old_pc;
        old_pc = m_pc;
        if (reset) begin
            m_busy = 1'b0; m_have = 1'b0; m_addr = 16'h0; m_buf = 16'h0;
            m_pc = 16'h0; m_ins = 16'h0; m_cnt = 32'h0;
        end else begin
            if (pcEn) m_pc = pcIncOrSet ? pcTarget : 16'((32'(m_pc) + 1) % 65536);
            if (m_busy) begin
                if (mem.memValid) begin
                    m_busy = 1'b0; m_have = 1'b1; m_buf = mem.memData;
                end
            end else if (m_have) begin
                if (irEn) begin
                    m_ins  = m_buf;
                    m_have = 1'b0;
`ifdef FETCH_ICOUNT_EN
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
`endif
                    if (fetchReq) begin
                        m_busy = 1'b1; m_addr = old_pc;
                    end
                end
            end else if (fetchReq) begin
                m_busy = 1'b1; m_addr = old_pc;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [5:0] ctl, input logic [15:0] tgt, input logic [15:0] md);
        {reset, fetchReq, pcEn, pcIncOrSet, irEn, mem.memValid} = ctl;
        pcTarget    = tgt;
        mem.memData = md;
        model_step();
        @(posedge clock);
        #1;
    endtask

    // ctl = {reset, fetchReq, pcEn, pcIncOrSet, irEn, memValid}
    typedef struct {
        logic [5:0]  ctl;
        logic [15:0] tgt;
        logic [15:0] md;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_rdy;
        logic [15:0] e_pc;
        logic [15:0] e_ins;
    } vec_t;

    vec_t tbl[$];

    initial begin
        reset = 1'b1; fetchReq = 1'b0; pcEn = 1'b0; pcIncOrSet = 1'b0;
        pcTarget = 16'h0; irEn = 1'b0; mem.memValid = 1'b0; mem.memData = 16'h0;

        tbl.push_back('{6'b100000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000});
        tbl.push_back('{6'b010000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000});
        tbl.push_back('{6'b000001, 16'h0000, 16'h1234, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000});
        tbl.push_back('{6'b000010, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h1234});
        tbl.push_back('{6'b010000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h1234});
        tbl.push_back('{6'b001000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0001, 16'h1234});
        tbl.push_back('{6'b000000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0001, 16'h1234});
        tbl.push_back('{6'b000000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0001, 16'h1234});
        tbl.push_back('{6'b000000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0001, 16'h1234});
        tbl.push_back('{6'b000001, 16'h0000, 16'hABCD, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h1234});
        tbl.push_back('{6'b010000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h1234});
        tbl.push_back('{6'b010010, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0001, 16'hABCD});
        tbl.push_back('{6'b000010, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0001, 16'hABCD});
        tbl.push_back('{6'b000001, 16'h0000, 16'h5555, 1'b0, 16'h0001, 1'b1, 16'h0001, 16'hABCD});
        tbl.push_back('{6'b000010, 16'h0000, 16'h0000, 1'b0, 16'h0001, 1'b0, 16'h0001, 16'h5555});
        tbl.push_back('{6'b000001, 16'h0000, 16'h9999, 1'b0, 16'h0001, 1'b0, 16'h0001, 16'h5555});
        tbl.push_back('{6'b001100, 16'hFFFF, 16'h0000, 1'b0, 16'h0001, 1'b0, 16'hFFFF, 16'h5555});
        tbl.push_back('{6'b001000, 16'h0000, 16'h0000, 1'b0, 16'h0001, 1'b0, 16'h0000, 16'h5555});
        tbl.push_back('{6'b001100, 16'h00A0, 16'h0000, 1'b0, 16'h0001, 1'b0, 16'h00A0, 16'h5555});
        tbl.push_back('{6'b010000, 16'h0000, 16'h0000, 1'b1, 16'h00A0, 1'b0, 16'h00A0, 16'h5555});
        tbl.push_back('{6'b000001, 16'h0000, 16'h1111, 1'b0, 16'h00A0, 1'b1, 16'h00A0, 16'h5555});
        tbl.push_back('{6'b000010, 16'h0000, 16'h0000, 1'b0, 16'h00A0, 1'b0, 16'h00A0, 16'h1111});
        tbl.push_back('{6'b011000, 16'h0000, 16'h0000, 1'b1, 16'h00A0, 1'b0, 16'h00A1, 16'h1111});
        tbl.push_back('{6'b100000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000});
        tbl.push_back('{6'b000001, 16'h0000, 16'h7777, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000});
        tbl.push_back('{6'b000000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000});

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].ctl, tbl[i].tgt, tbl[i].md);
            chk($sformatf("v%0d_memReq", i),      32'(mem.memReq),  32'(tbl[i].e_req));
            chk($sformatf("v%0d_memAddr", i),     32'(mem.memAddr), 32'(tbl[i].e_addr));
            chk($sformatf("v%0d_fetchReady", i),  32'(fetchReady),  32'(tbl[i].e_rdy));
            chk($sformatf("v%0d_pc", i),          32'(pc),          32'(tbl[i].e_pc));
            chk($sformatf("v%0d_instruction", i), 32'(instruction), 32'(tbl[i].e_ins));
        end

        // Three complete fetch/issue rounds with latency 3.
        apply(6'b100000, 16'h0, 16'h0);
        for (int r = 0; r < 3; r++) begin
            int n;
            apply(6'b010000, 16'h0, 16'h0);
            apply(6'b000000, 16'h0, 16'h0);
            apply(6'b000000, 16'h0, 16'h0);
            apply(6'b000001, 16'h0, 16'(16'hC000 + r));
            n = 0;
            while (!fetchReady && n < 8) begin
                apply(6'b000000, 16'h0, 16'h0);
                n++;
            end
            chk($sformatf("round%0d_fetchReady", r), 32'(fetchReady), 32'd1);
            apply(6'b000010, 16'h0, 16'h0);
            chk($sformatf("round%0d_instruction", r), 32'(instruction), 32'(16'hC000 + r));
        end
`ifdef FETCH_ICOUNT_EN
        chk("icount_after_3", instrCount, 32'd3);
`else
        chk("icount_after_3", instrCount, 32'd0);
`endif

        // Randomised traffic against the reference.
        apply(6'b100000, 16'h0, 16'h0);
        for (int c = 0; c < 3000; c++) begin
            logic [5:0] ctl;
            ctl[5] = ($urandom_range(0, 99) < 1);
            ctl[4] = ($urandom_range(0, 99) < 40);
            ctl[3] = ($urandom_range(0, 99) < 20);
            ctl[2] = ($urandom_range(0, 99) < 50);
            ctl[1] = ($urandom_range(0, 99) < 40);
            ctl[0] = ($urandom_range(0, 99) < 30);
            apply(ctl, 16'($urandom), 16'($urandom));
            chk("rnd_memReq",      32'(mem.memReq),  32'(m_busy));
            chk("rnd_memAddr",     32'(mem.memAddr), 32'(m_addr));
            chk("rnd_fetchReady",  32'(fetchReady),  32'(m_have));
            chk("rnd_pc",          32'(pc),          32'(m_pc));
            chk("rnd_instruction", 32'(instruction), 32'(m_ins));
            chk("rnd_instrCount",  instrCount,       m_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
